// File: rtl/dice_roller_pkg.sv
// Shared constants, roller state encoding and the die-step helper for the craps dice roller.
package dice_roller_pkg;

  localparam int unsigned DIE_W = 3;
  localparam int unsigned SUM_W = 4;

  localparam logic [DIE_W-1:0] DIE_MIN  = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX  = 3'd6;
  localparam logic [SUM_W-1:0] SUM_NONE = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TUMBLE = 2'b01,
    ST_SETTLE = 2'b10
  } roller_state_t;

  // One step of a single die, wrapping 6 -> 1.
  function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] d);
    return (d == DIE_MAX) ? DIE_MIN : d + DIE_W'(1);
  endfunction

endpackage

// File: rtl/dice_roller_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer; emits single-cycle press/release pulses.
module dice_roller_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press_c,
  output logic o_release_c
);

  logic             r_s0;
  logic             r_s1;
  logic             r_clean;
  logic             r_clean_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_btn;
      r_s1 <= r_s0;
    end
  end

  // Accept a new level only after it has differed from clean for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_clean_d <= r_clean;
      if (r_s1 != r_clean) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_clean <= r_s1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press_c   = r_clean & ~r_clean_d;
  assign o_release_c = ~r_clean & r_clean_d;

endmodule

// File: rtl/dice_roller.sv
// Craps dice roller: tumbles two dice while ROLL is held, freezes them on release and strobes the result.
module dice_roller
  import dice_roller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll_btn,
  output logic [DIE_W-1:0] die1,
  output logic [DIE_W-1:0] die2,
  output logic [SUM_W-1:0] sum,
  output logic             roll_done,
  output logic             rolling
);

  logic w_press;
  logic w_release;

  roller_state_t    r_state;
  roller_state_t    w_state_nxt;
  logic [DIE_W-1:0] r_die1;
  logic [DIE_W-1:0] r_die2;
  logic [SUM_W-1:0] r_sum;
  logic             r_roll_done;
  logic             r_rolling;

  dice_roller_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_btn       (roll_btn),
    .o_press_c   (w_press),
    .o_release_c (w_release)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_press)   w_state_nxt = ST_TUMBLE;
      ST_TUMBLE: if (w_release) w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rolling   <= 1'b0;
      r_roll_done <= 1'b0;
      r_sum       <= SUM_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_rolling   <= (w_state_nxt == ST_TUMBLE);
      r_roll_done <= (r_state == ST_SETTLE);
      if (r_state == ST_SETTLE) begin
        r_sum <= SUM_W'(r_die1) + SUM_W'(r_die2);
      end
    end
  end

  // The two dice form one 36-state counter: die2 steps only when die1 wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_die1 <= DIE_MIN;
      r_die2 <= DIE_MIN;
    end else if (r_state == ST_TUMBLE) begin
      r_die1 <= die_next(r_die1);
      if (r_die1 == DIE_MAX) begin
        r_die2 <= die_next(r_die2);
      end
    end
  end

  assign die1      = r_die1;
  assign die2      = r_die2;
  assign sum       = r_sum;
  assign roll_done = r_roll_done;
  assign rolling   = r_rolling;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with a short debounce window; rolls are table driven.
module tb_dice_roller;

  logic       clock = 1'b0;
  logic       reset;
  logic       roll_btn;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       roll_done;
  logic       rolling;

  int total = 0;
  int bad   = 0;

  int   mon_done = 0;
  int   mon_b2b  = 0;
  int   mon_roll = 0;
  logic mon_prev = 1'b0;

  always #5 clock = ~clock;

  dice_roller #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .roll_btn  (roll_btn),
    .die1      (die1),
    .die2      (die2),
    .sum       (sum),
    .roll_done (roll_done),
    .rolling   (rolling)
  );

  // Running counts of strobes, back-to-back strobes and cycles spent rolling.
  always @(negedge clock) begin
    if (roll_done) begin
      mon_done++;
      if (mon_prev) mon_b2b++;
    end
    mon_prev = roll_done;
    if (rolling) mon_roll++;
  end

  typedef struct {
    bit do_reset;
    int hold;
    int e_d1;
    int e_d2;
    int e_sum;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " die1"}, int'(die1), 1);
    check({tag, " die2"}, int'(die2), 1);
    check({tag, " sum"}, int'(sum), 0);
    check({tag, " roll_done"}, int'(roll_done), 0);
    check({tag, " rolling"}, int'(rolling), 0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic press_hold(input int h);
    @(negedge clock);
    roll_btn = 1'b1;
    repeat (h) @(negedge clock);
    roll_btn = 1'b0;
  endtask

  // Wait (bounded) for the strobe, then check one clean strobe, tumble length and frozen values.
  task automatic await_roll(input string tag, input int done0, input int b2b0, input int roll0,
                            input int k, input int e1, input int e2, input int es);
    int n = 0;
    while (mon_done == done0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, " strobe seen before timeout"}, int'(n < 100), 1);
    repeat (10) @(negedge clock);
    check({tag, " strobe count"}, mon_done - done0, 1);
    check({tag, " back-to-back strobes"}, mon_b2b - b2b0, 0);
    check({tag, " tumble cycles"}, mon_roll - roll0, k);
    check({tag, " die1"}, int'(die1), e1);
    check({tag, " die2"}, int'(die2), e2);
    check({tag, " sum"}, int'(sum), es);
    check({tag, " rolling idle"}, int'(rolling), 0);
  endtask

  initial begin
    int d0;
    int b0;
    int r0;
    int n;

    // Expected dice: index (d1-1)+6*(d2-1) advances by hold count mod 36.
    vecs[0] = '{1'b1,  7, 2, 2,  4};
    vecs[1] = '{1'b1, 35, 6, 6, 12};
    vecs[2] = '{1'b0, 37, 1, 1,  2};
    vecs[3] = '{1'b0,  5, 6, 1,  7};
    vecs[4] = '{1'b0, 12, 6, 3,  9};

    reset    = 1'b1;
    roll_btn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("in reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("after reset");

    // Glitches shorter than the debounce window must not start a roll.
    d0 = mon_done;
    r0 = mon_roll;
    @(negedge clock);
    roll_btn = 1'b1;
    repeat (3) @(negedge clock);
    roll_btn = 1'b0;
    @(negedge clock);
    roll_btn = 1'b1;
    repeat (2) @(negedge clock);
    roll_btn = 1'b0;
    repeat (20) @(negedge clock);
    check("glitch strobes", mon_done - d0, 0);
    check("glitch rolling cycles", mon_roll - r0, 0);
    check("glitch die1", int'(die1), 1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_reset) apply_reset();
      d0 = mon_done;
      b0 = mon_b2b;
      r0 = mon_roll;
      press_hold(vecs[i].hold);
      await_roll($sformatf("roll%0d", i), d0, b0, r0, vecs[i].hold,
                 vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_sum);
    end

    // Reset while tumbling, button held through reset.
    d0 = mon_done;
    @(negedge clock);
    roll_btn = 1'b1;
    n = 0;
    while (!rolling && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("mid-tumble rolling reached", int'(rolling), 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("mid-tumble reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("no strobe across reset", mon_done - d0, 0);
    d0 = mon_done;
    b0 = mon_b2b;
    r0 = mon_roll;
    repeat (9) @(negedge clock);
    roll_btn = 1'b0;
    await_roll("re-press", d0, b0, r0, 9, 4, 2, 6);

    // Release bounce: high 10, low 1, high 1, then stable low -> tumble of 12.
    d0 = mon_done;
    b0 = mon_b2b;
    r0 = mon_roll;
    @(negedge clock);
    roll_btn = 1'b1;
    repeat (10) @(negedge clock);
    roll_btn = 1'b0;
    @(negedge clock);
    roll_btn = 1'b1;
    @(negedge clock);
    roll_btn = 1'b0;
    await_roll("bounce", d0, b0, r0, 12, 4, 4, 8);
    repeat (10) @(negedge clock);
    check("bounce die1 stable", int'(die1), 4);
    check("bounce die2 stable", int'(die2), 4);
    check("bounce late strobes", mon_done - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
